// File: rtl/uart_rx_if.sv
// uart_rx_if -- bundle of the serial receiver's line input and byte outputs.
//   rx         : serial line into the receiver (idles high)
//   data       : last correctly framed byte
//   data_valid : one-cycle pulse when data is updated
//   frame_err  : one-cycle pulse when a stop bit is sampled low
//   busy       : receiver is not idle
//   dbg_state  : current receiver state encoding, for observation only
// Modport slave is the receiver side; master is the line driver / consumer.
// Handshake: data_valid and frame_err are unacknowledged single-cycle
// strobes; a consumer must capture data in the cycle data_valid is high.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] dbg_state;

  modport master (
    output rx,
    input  data, data_valid, frame_err, busy, dbg_state
  );

  modport slave (
    input  rx,
    output data, data_valid, frame_err, busy, dbg_state
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with 16x oversampling and 2-of-3 majority
// voting at ticks 7/8/9 of every bit period.
//   clk   : sole clock, rising edge
//   rst   : asynchronous active-high reset
//   rx_if : uart_rx_if.slave (rx in; data, data_valid, frame_err, busy,
//           dbg_state out)
// BAUD_DIV is the number of clk cycles per 1/16 bit period (2..65535).
module uart_rx #(
  parameter int unsigned BAUD_DIV = 27
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave rx_if
);

  localparam logic [15:0] DIV_MAX = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      state_q, state_d;

  logic        rx_meta_q, rxs_q, rx_prev_q;
  logic [15:0] div_q, div_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        s7_q, s7_d, s8_q, s8_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_err_q, frame_err_d;

  logic        running;
  logic        tick;
  logic        fall;
  logic        maj;
  logic        mid_bit;
  logic        end_bit;

  // Divider and tick counter only advance while a frame is being sampled.
  assign running = (state_q == S_START) || (state_q == S_DATA) ||
                   (state_q == S_STOP);
  assign tick    = running && (div_q == DIV_MAX);
  assign fall    = rx_prev_q && !rxs_q;
  // The tick-9 sample is taken live from rxs on the resolving edge.
  assign maj     = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);
  assign mid_bit = tick && (tick_cnt_q == 4'd9);
  assign end_bit = tick && (tick_cnt_q == 4'd15);

  // Synchronizer and edge register; all idle high so reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_if.rx;
      rxs_q     <= rx_meta_q;
      rx_prev_q <= rxs_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fall) state_d = S_START;
      S_START: begin
        if (mid_bit && maj) begin
          state_d = S_IDLE;            // false start, glitch on the line
        end else if (end_bit) begin
          state_d = S_DATA;
        end
      end
      S_DATA:  if (end_bit && (bit_idx_q == 3'd7)) state_d = S_STOP;
      // Leaving at the stop-bit midpoint lets a back-to-back start bit
      // be caught by the IDLE edge detector.
      S_STOP:  if (mid_bit) state_d = maj ? S_IDLE : S_BREAK;
      S_BREAK: if (rxs_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters and sample capture.
  always_comb begin
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    s7_d       = s7_q;
    s8_d       = s8_q;
    shift_d    = shift_q;
    if (!running) begin
      // Held at zero outside a frame, so a start edge begins from a clean
      // divider, tick counter and bit index.
      div_d      = 16'd0;
      tick_cnt_d = 4'd0;
      bit_idx_d  = 3'd0;
    end else begin
      if (tick) begin
        div_d      = 16'd0;
        tick_cnt_d = tick_cnt_q + 4'd1;  // wraps 15 -> 0
      end else begin
        div_d      = div_q + 16'd1;
      end
      if (tick && (tick_cnt_q == 4'd7)) s7_d = rxs_q;
      if (tick && (tick_cnt_q == 4'd8)) s8_d = rxs_q;
      if ((state_q == S_DATA) && mid_bit) shift_d[bit_idx_q] = maj;
      if ((state_q == S_DATA) && end_bit) bit_idx_d = bit_idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= 16'd0;
      tick_cnt_q <= 4'd0;
      bit_idx_q  <= 3'd0;
      s7_q       <= 1'b1;
      s8_q       <= 1'b1;
      shift_q    <= 8'h00;
    end else begin
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      s7_q       <= s7_d;
      s8_q       <= s8_d;
      shift_q    <= shift_d;
    end
  end

  // Output logic: strobes are computed here and registered below.
  always_comb begin
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if ((state_q == S_STOP) && mid_bit) begin
      if (maj) begin
        data_d       = shift_q;
        data_valid_d = 1'b1;
      end else begin
        frame_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q       <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_if.data       = data_q;
  assign rx_if.data_valid = data_valid_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.busy       = (state_q != S_IDLE);
  assign rx_if.dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx with BAUD_DIV=4
// (one bit = 64 clk). Expected receiver events are queued as frames are
// driven; a negedge monitor pops and compares them as the DUT emits them.
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic clk;
  logic rst;
  uart_rx_if bus ();

  uart_rx #(.BAUD_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Each entry: {is_frame_err, expected data bus value}.
  logic [8:0] exp_q[$];
  logic [7:0] last_good;
  int n_cmp;
  int n_bad;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic hold(input logic v, input int cycles);
    bus.rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Drives one full frame. glitch_bit >= 0 inverts that data bit for 4 clk
  // around its tick-8 sample point.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int glitch_bit);
    if (stop) begin
      exp_q.push_back({1'b0, b});
      last_good = b;
    end else begin
      exp_q.push_back({1'b1, last_good});
    end
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        hold(b[i], 34);
        hold(~b[i], 4);
        hold(b[i], BIT_CLK - 38);
      end else begin
        hold(b[i], BIT_CLK);
      end
    end
    hold(stop, BIT_CLK);
  endtask

  // ---------------- monitor ----------------
  logic [7:0] prev_data;
  always @(negedge clk) begin
    if (rst) begin
      prev_data = bus.data;
    end else begin
      if (bus.data_valid || bus.frame_err) begin
        check("pulse_exclusive", int'(bus.data_valid & bus.frame_err), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {23'd0, bus.frame_err, bus.data}, 'h1ff);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check(bus.frame_err ? "frame_err_event" : "data_event",
                {23'd0, bus.frame_err, bus.data}, {23'd0, e});
        end
      end
      if (bus.data != prev_data) begin
        check("data_changes_only_with_valid", int'(bus.data_valid), 1);
      end
      prev_data = bus.data;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    last_good = 8'h00;
    bus.rx    = 1'b1;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",  int'(bus.data), 0);
    check("rst_valid", int'(bus.data_valid), 0);
    check("rst_ferr",  int'(bus.frame_err), 0);
    check("rst_busy",  int'(bus.busy), 0);
    check("rst_state", int'(bus.dbg_state), 0);
    rst = 1'b0;
    hold(1'b1, 10);

    // Valid frame.
    send_frame(8'hA5, 1'b1, -1);
    hold(1'b1, 5);
    check("busy_after_A5", int'(bus.busy), 0);

    // Stop bit low, line held low for two more bit periods.
    send_frame(8'h3C, 1'b0, -1);
    hold(1'b0, BIT_CLK);
    check("busy_in_break", int'(bus.busy), 1);
    hold(1'b0, BIT_CLK);
    check("busy_in_break_late", int'(bus.busy), 1);
    check("data_kept_after_err", int'(bus.data), 'hA5);
    hold(1'b1, 6);
    check("busy_after_break", int'(bus.busy), 0);

    // False start: 20 clk low pulse.
    hold(1'b0, 20);
    hold(1'b1, 2 * BIT_CLK);
    check("busy_after_false_start", int'(bus.busy), 0);
    send_frame(8'h5A, 1'b1, -1);
    hold(1'b1, 10);

    // Back-to-back frames.
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    hold(1'b1, 10);

    // Glitch on data bit 3 near its tick-8 sample.
    send_frame(8'h81, 1'b1, 3);
    hold(1'b1, 10);
    check("data_after_glitch", int'(bus.data), 'h81);

    // Reset in the middle of data bit 4.
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) hold(1'($urandom_range(0, 1)), BIT_CLK);
    hold(1'b1, 30);
    #2 rst = 1'b1;
    #1;
    check("midrst_data",  int'(bus.data), 0);
    check("midrst_valid", int'(bus.data_valid), 0);
    check("midrst_ferr",  int'(bus.frame_err), 0);
    check("midrst_busy",  int'(bus.busy), 0);
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 10);
    send_frame(8'hC3, 1'b1, -1);
    hold(1'b1, 10);
    check("data_after_reset_frame", int'(bus.data), 'hC3);

    // Randomized frames: random byte, occasional bad stop bit, random gap.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      logic       ok;
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 9) != 0);
      send_frame(b, ok, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
      hold(1'b1, ok ? int'($urandom_range(0, 40)) : int'($urandom_range(4, 40)));
    end

    // Drain with a bounded wait.
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    hold(1'b1, 5);
    check("final_busy", int'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 27, meaning clk cycles per 1/16 bit period; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line; idles high.
REQ-005 SHALL have port data  output  8  last correctly framed byte, registered.
REQ-006 SHALL have port data_valid  output  1  one-cycle pulse when data is updated.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse on a stop-bit error.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-009 SHALL accept frames of 1 start bit (0), 8 data bits LSB first (data[0] first, data[7] last), and 1 stop bit (1).
REQ-010 SHALL pass rx through a 2-flop synchronizer whose flops reset to 1; all logic below uses the synchronized value rxs.
REQ-011 SHALL generate an oversample tick from a 16-bit divider counting 0..BAUD_DIV-1; tick is asserted when the count equals BAUD_DIV-1, then the count wraps to 0.
REQ-012 SHALL count ticks 0..15 per bit period with a 4-bit counter; tick 15 ends the bit, and the counter wraps to 0.
REQ-013 SHALL sample rxs at ticks 7, 8 and 9 of each bit period; the bit value SHALL be the 2-of-3 majority, resolved on the tick-9 edge.
REQ-014 SHALL implement states IDLE, START, DATA, STOP and BREAK.
REQ-015 IDLE: a falling edge on rxs (previous 1, current 0) SHALL move the block to START and clear the divider, tick counter and bit index in the same edge.
REQ-016 START: a majority of 1 SHALL be treated as a false start and return to IDLE at tick 9 with no output pulse; a majority of 0 SHALL move to DATA after tick 15.
REQ-017 DATA: each majority bit SHALL be stored in a shift register at bit index 0..7; after tick 15 of bit index 7 the block SHALL enter STOP.
REQ-018 STOP, majority 1: on the tick-9 edge the block SHALL load data from the shift register, pulse data_valid for exactly one cycle, and go to IDLE.
REQ-019 STOP, majority 0: on the tick-9 edge the block SHALL pulse frame_err for one cycle, leave data unchanged, and go to BREAK.
REQ-020 BREAK: SHALL stay in BREAK until rxs is 1, then go to IDLE; a falling edge is only accepted from IDLE.
REQ-021 Returning to IDLE at stop-bit tick 9 SHALL allow a back-to-back frame whose start edge arrives at any point after the stop-bit midpoint to be received.
REQ-022 data_valid and frame_err SHALL never be asserted in the same cycle; data SHALL change only in a cycle with data_valid.
REQ-023 Latency: data_valid SHALL rise 1 cycle after the stop-bit tick-9 tick; the start edge SHALL be detected 2-3 cycles after the rx transition.

Reset
REQ-024 When rst is asserted, state SHALL become IDLE, data 8'h00, data_valid 0, frame_err 0, busy 0, synchronizer flops and edge register 1, and all counters 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame without any output pulse; the first falling edge after release SHALL start a new frame.

Verification (BAUD_DIV=4, so 1 bit = 64 clk)
REQ-026 Drive frame 0xA5 with a valid stop bit -> data=8'hA5, data_valid high for exactly 1 cycle, busy low afterwards, frame_err stays 0.
REQ-027 Drive frame 0x3C with stop bit = 0 and hold rx low for 2 more bit periods -> one frame_err pulse, data keeps its prior value, busy stays high until rx returns high, then IDLE.
REQ-028 Drive rx low for 20 clk, then high -> false start, back to IDLE, no data_valid and no frame_err; a following 0x5A frame is received correctly.
REQ-029 Drive 0x00 and 0xFF back-to-back, with the second start bit immediately after the stop bit -> two data_valid pulses carrying 8'h00 then 8'hFF.
REQ-030 Invert rx for one tick period (4 clk) around tick 8 of data bit 3 in frame 0x81 -> majority vote corrects the glitch and data=8'h81.
REQ-031 Assert rst during data bit 4 -> all outputs at reset values immediately (asynchronously); after release, frame 0xC3 is received correctly with no spurious pulse beforehand.
